// File: rtl/spi_pkg.sv
// Shared constants for the SPI target: FSM state codes, data width and
// the helper that picks which spi_clk edge samples mosi.
package spi_pkg;

  localparam int DATA_W  = 8;
  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LOAD  = 4'd1;
  localparam logic [3:0] ST_SHIFT = 4'd2;
  localparam logic [3:0] ST_DONE  = 4'd3;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic polarity, input logic phase);
    return polarity == phase;
  endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for one asynchronous input; RST_VAL sets the
// value both flops take while reset is held low.
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_target.sv
// SPI target (all four CPOL/CPHA modes) oversampled in the clk domain, with a
// one-byte transmit holding register and a per-byte receive strobe.
module spi_target
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              polarity,
  input  logic              phase,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic [3:0]        state,
  output logic [3:0]        count
);

  logic spi_clk_s;
  logic cs_s;
  logic mosi_s;

  spi_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(spi_clk), .q(spi_clk_s));
  spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs),      .q(cs_s));
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi),    .q(mosi_s));

  logic              spi_clk_prev_q, spi_clk_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              miso_q, miso_d;

  logic              clk_rise, clk_fall;
  logic              sample_edge, shift_edge;
  logic              cs_fall, cs_rise;
  logic              tx_write, hold_take;
  logic [DATA_W-1:0] load_byte;

  assign clk_rise    = spi_clk_s & ~spi_clk_prev_q;
  assign clk_fall    = ~spi_clk_s & spi_clk_prev_q;
  assign sample_edge = sample_on_rise(polarity, phase) ? clk_rise : clk_fall;
  assign shift_edge  = sample_on_rise(polarity, phase) ? clk_fall : clk_rise;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign tx_write    = tx_valid & ~hold_full_q;
  assign load_byte   = hold_full_q ? hold_q : '0;

  always_comb begin
    spi_clk_prev_d = spi_clk_s;
    cs_prev_d      = cs_s;
    settle_d       = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // The cs synchroniser leaves reset high, so a frame already in progress at
    // reset release would look like a fresh falling edge; only arm once cs has
    // been seen high after the synchroniser has flushed.
    armed_d        = armed_q | ((settle_q == 2'd3) & cs_s);
    state_d        = state_q;
    count_d        = count_q;
    tx_shift_d     = tx_shift_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    miso_d         = miso_q;
    hold_take      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        miso_d  = 1'b0;
        if (cs_fall && armed_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          hold_take  = 1'b1;
          underrun_d = ~hold_full_q;
          if (!phase) begin
            miso_d     = load_byte[DATA_W-1];
            tx_shift_d = {load_byte[DATA_W-2:0], 1'b0};
          end else begin
            tx_shift_d = load_byte;
          end
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          // With CPHA=0 bit 7 is already out, so the shift edge before the
          // first sample (e.g. the trailing edge of the previous byte) is skipped.
          if (shift_edge && (phase || count_q != 4'd0)) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (count_q == 4'd7) begin
              count_d = '0;
              state_d = ST_DONE;
            end else begin
              count_d = count_q + 4'd1;
            end
          end
        end
      end
      ST_DONE: begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        state_d    = cs_s ? ST_IDLE : ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    hold_d      = tx_write ? tx_data : hold_q;
    hold_full_d = tx_write ? 1'b1 : (hold_take ? 1'b0 : hold_full_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spi_clk_prev_q <= 1'b0;
      cs_prev_q      <= 1'b1;
      settle_q       <= '0;
      armed_q        <= 1'b0;
      state_q        <= ST_IDLE;
      count_q        <= '0;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      spi_clk_prev_q <= spi_clk_prev_d;
      cs_prev_q      <= cs_prev_d;
      settle_q       <= settle_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      count_q        <= count_d;
      tx_shift_q     <= tx_shift_d;
      rx_shift_q     <= rx_shift_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      underrun_q     <= underrun_d;
      miso_q         <= miso_d;
    end
  end

  assign miso_oe     = ~cs_s;
  assign miso        = miso_oe & miso_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign state       = state_q;
  assign count       = count_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives an SPI initiator in all four modes and
// checks received bytes, miso bit streams, status pulses and reset behaviour.
module tb_spi_target;

  localparam int H = 8;  // spi_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_clk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       polarity = 1'b0;
  logic       phase = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun;
  logic [7:0] rx_data;
  logic [3:0] state, count;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         urun_cnt = 0;
  logic [7:0] rx_log[$];

  spi_target dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .polarity(polarity), .phase(phase),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .state(state), .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun === 1'b1) urun_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_wait got %b want 1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    $display("tx write %h", d);
  endtask

  task automatic start_frame(input logic pol, input logic pha);
    @(negedge clk);
    polarity = pol;
    phase = pha;
    spi_clk = pol;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic xfer_byte(input logic [7:0] m, input logic last, output logic [7:0] s);
    for (int i = 7; i >= 0; i--) begin
      if (!phase) begin
        mosi = m[i];
        repeat (H) @(negedge clk);
        s[i] = miso;
        spi_clk = ~polarity;
        if (i > 0 || !last) begin
          repeat (H) @(negedge clk);
          spi_clk = polarity;
        end
      end else begin
        spi_clk = ~polarity;
        mosi = m[i];
        repeat (H) @(negedge clk);
        s[i] = miso;
        spi_clk = polarity;
        if (i > 0 || !last) repeat (H) @(negedge clk);
      end
    end
    $display("spi byte mode%0d mosi %h miso %h", {polarity, phase}, m, s);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = polarity;
    repeat (H) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", miso); end
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL rst_miso_oe got %b want 0", miso_oe); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
    if ({rx_valid, tx_underrun} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b want 00", {rx_valid, tx_underrun}); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_mode3();
    logic [7:0] s;
    int rx0 = rx_cnt;
    int ur0 = urun_cnt;
    write_tx(8'h5A);
    start_frame(1'b1, 1'b1);
    xfer_byte(8'hAF, 1'b1, s);
    end_frame();
    checks += 5;
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL m3_rx_pulses got %0d want 1", rx_cnt - rx0); end
    if (rx_data !== 8'hAF) begin errors++; $display("FAIL m3_rx_data got %h want af", rx_data); end
    if (s !== 8'h5A) begin errors++; $display("FAIL m3_miso got %h want 5a", s); end
    if (urun_cnt != ur0) begin errors++; $display("FAIL m3_underrun got %0d want 0", urun_cnt - ur0); end
    if (state !== 4'd0) begin errors++; $display("FAIL m3_idle got %0d want 0", state); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s1, s2;
    int rx0 = rx_cnt;
    int ur0 = urun_cnt;
    write_tx(8'hC3);
    start_frame(1'b0, 1'b0);
    write_tx(8'h3C);
    xfer_byte(8'h12, 1'b0, s1);
    xfer_byte(8'h34, 1'b1, s2);
    end_frame();
    checks += 5;
    if (rx_cnt - rx0 != 2) begin errors++; $display("FAIL b2b_rx_pulses got %0d want 2", rx_cnt - rx0); end
    else begin
      checks += 2;
      if (rx_log[rx_log.size()-2] !== 8'h12) begin errors++; $display("FAIL b2b_rx0 got %h want 12", rx_log[rx_log.size()-2]); end
      if (rx_log[rx_log.size()-1] !== 8'h34) begin errors++; $display("FAIL b2b_rx1 got %h want 34", rx_log[rx_log.size()-1]); end
    end
    if (s1 !== 8'hC3) begin errors++; $display("FAIL b2b_miso0 got %h want c3", s1); end
    if (s2 !== 8'h3C) begin errors++; $display("FAIL b2b_miso1 got %h want 3c", s2); end
    if (urun_cnt != ur0) begin errors++; $display("FAIL b2b_underrun got %0d want 0", urun_cnt - ur0); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_tx_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_underrun();
    logic [7:0] s;
    int rx0 = rx_cnt;
    int ur0 = urun_cnt;
    start_frame(1'b0, 1'b1);
    xfer_byte(8'h96, 1'b1, s);
    end_frame();
    checks += 4;
    if (urun_cnt - ur0 != 1) begin errors++; $display("FAIL ur_pulses got %0d want 1", urun_cnt - ur0); end
    if (s !== 8'h00) begin errors++; $display("FAIL ur_miso got %h want 00", s); end
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL ur_rx_pulses got %0d want 1", rx_cnt - rx0); end
    if (rx_data !== 8'h96) begin errors++; $display("FAIL ur_rx_data got %h want 96", rx_data); end
  endtask

  task automatic test_cs_abort();
    logic [7:0] s;
    logic [4:0] part;
    int rx0;
    write_tx(8'hAA);
    start_frame(1'b0, 1'b0);
    write_tx(8'h55);
    rx0 = rx_cnt;
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      repeat (H) @(negedge clk);
      part[4-i] = miso;
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks += 3;
    if (state !== 4'd2) begin errors++; $display("FAIL abort_mid_state got %0d want 2", state); end
    if (count !== 4'd5) begin errors++; $display("FAIL abort_mid_count got %0d want 5", count); end
    if (part !== 5'b10101) begin errors++; $display("FAIL abort_part_miso got %b want 10101", part); end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    checks += 5;
    if (state !== 4'd0) begin errors++; $display("FAIL abort_state got %0d want 0", state); end
    if (count !== 4'd0) begin errors++; $display("FAIL abort_count got %0d want 0", count); end
    if (rx_cnt != rx0) begin errors++; $display("FAIL abort_rx_pulses got %0d want 0", rx_cnt - rx0); end
    if (rx_data !== 8'h96) begin errors++; $display("FAIL abort_rx_data got %h want 96", rx_data); end
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL abort_hold got %b want 0", tx_ready); end
    $display("cs abort after 5 bits");
    start_frame(1'b0, 1'b0);
    xfer_byte(8'hC5, 1'b1, s);
    end_frame();
    checks += 2;
    if (s !== 8'h55) begin errors++; $display("FAIL abort_next_miso got %h want 55", s); end
    if (rx_data !== 8'hC5) begin errors++; $display("FAIL abort_next_rx got %h want c5", rx_data); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s;
    int rx0;
    int ur0;
    write_tx(8'hE7);
    start_frame(1'b1, 1'b0);
    write_tx(8'h81);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
      repeat (H) @(negedge clk);
      spi_clk = 1'b1;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 8;
    if (state !== 4'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", state); end
    if (count !== 4'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
    if (miso !== 1'b0) begin errors++; $display("FAIL rmid_miso got %b want 0", miso); end
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL rmid_miso_oe got %b want 0", miso_oe); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_rx_valid got %b want 0", rx_valid); end
    if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rmid_underrun got %b want 0", tx_underrun); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_tx_ready got %b want 1", tx_ready); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx0 = rx_cnt;
    for (int i = 0; i < 12; i++) begin
      repeat (H) @(negedge clk);
      spi_clk = ~spi_clk;
    end
    repeat (4) @(negedge clk);
    checks += 2;
    if (state !== 4'd0) begin errors++; $display("FAIL rmid_wait_state got %0d want 0", state); end
    if (rx_cnt != rx0) begin errors++; $display("FAIL rmid_wait_rx got %0d want 0", rx_cnt - rx0); end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    $display("reset mid-frame released");
    rx0 = rx_cnt;
    ur0 = urun_cnt;
    start_frame(1'b1, 1'b0);
    xfer_byte(8'hFF, 1'b1, s);
    end_frame();
    checks += 4;
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL rmid_rx_pulses got %0d want 1", rx_cnt - rx0); end
    if (rx_data !== 8'hFF) begin errors++; $display("FAIL rmid_rx_data got %h want ff", rx_data); end
    if (s !== 8'h00) begin errors++; $display("FAIL rmid_miso got %h want 00", s); end
    if (urun_cnt - ur0 != 1) begin errors++; $display("FAIL rmid_underrun got %0d want 1", urun_cnt - ur0); end
  endtask

  initial begin
    test_reset();
    test_mode3();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 clk  input  1  system clock; all logic on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-003 spi_clk  input  1  serial clock from the SPI initiator; asynchronous to clk; frequency at most clk/8.
REQ-004 cs  input  1  chip select, active-low, asynchronous.
REQ-005 mosi  input  1  serial data from the initiator, MSB first.
REQ-006 miso  output  1  serial data to the initiator, MSB first.
REQ-007 miso_oe  output  1  1 while the target owns miso (cs asserted).
REQ-008 polarity  input  1  CPOL; static while cs is low.
REQ-009 phase  input  1  CPHA; static while cs is low.
REQ-010 tx_data  input  8  next byte to transmit.
REQ-011 tx_valid  input  1  tx_data valid.
REQ-012 tx_ready  output  1  transmit holding register empty.
REQ-013 rx_data  output  8  last fully received byte.
REQ-014 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-015 tx_underrun  output  1  one-clk pulse when a byte starts with an empty holding register.
REQ-016 state  output  4  current FSM state encoding, for debug.
REQ-017 count  output  4  bits sampled in the current byte (0-7), for debug.

Function
REQ-018 spi_clk, cs and mosi each pass through a 2-FF synchroniser; edges are detected on the synchronised spi_clk.
- Sample edge: rising when polarity==phase, falling otherwise.
- Shift edge: the opposite edge.
REQ-019 The FSM states are IDLE=0, LOAD=1, SHIFT=2, DONE=3; all other codes return to IDLE.
REQ-020 IDLE -> LOAD on the synchronised cs falling edge.
REQ-021 LOAD lasts one clk: the shift register loads from the holding register, or 8'h00 with tx_underrun=1 if the holding register is empty; the FSM then enters SHIFT.
REQ-022 Bit output on miso:
- phase=0: bit 7 drives miso from the end of LOAD.
- phase=1: bit 7 drives miso on the first shift edge.
- Each later shift edge presents the next lower bit.
REQ-023 On each sample edge in SHIFT, synchronised mosi shifts into rx_shift LSB and count increments.
REQ-024 On the 8th sample edge, count wraps to 0 and the FSM enters DONE.
REQ-025 DONE lasts one clk: rx_data <= rx_shift, rx_valid=1; the FSM then enters LOAD if cs is still low, otherwise IDLE.
- Back-to-back bytes within one cs frame are supported.
REQ-026 Holding register:
- Written when tx_valid && tx_ready.
- tx_ready = ~full.
- Emptied in LOAD.
- A write and an empty in the same clk leave the register full with the new byte.
REQ-027 Synchronised cs rising edge in any state:
- FSM -> IDLE and count -> 0.
- No rx_valid for a partial byte; rx_data is unchanged.
- The holding register is retained.
REQ-028 miso_oe = ~synchronised cs; miso = 0 whenever miso_oe = 0.
REQ-029 Spurious spi_clk edges in IDLE are ignored.

Reset
REQ-030 While reset=0, the block holds these values:
- state=IDLE, count=0.
- miso=0, miso_oe=0.
- rx_data=8'h00, rx_valid=0, tx_underrun=0.
- tx_ready=1, holding register empty.
- Synchroniser flops: cs=1, mosi=0, spi_clk=0.
REQ-031 Reset asserted mid-frame aborts the frame. After release, the block waits for a fresh cs falling edge.

Structure
REQ-032 A shared package spi_pkg holds:
- State encodings.
- Constant DATA_W=8.
- Function for the sample-edge mode select.
REQ-033 One sub-module, spi_sync2, is the 2-FF synchroniser with a reset-value parameter. It is instanced three times.

Verification
REQ-034 Mode 3 (polarity=1, phase=1), tx_data=8'h5A preloaded; the initiator sends 8'hAF -> rx_data=8'hAF, one rx_valid pulse; miso sequence 0,1,0,1,1,0,1,0.
REQ-035 Mode 0, two bytes 8'h12 then 8'h34 in one cs frame, tx bytes 8'hC3 and 8'h3C written between them -> two rx_valid pulses, rx_data 8'h12 then 8'h34, miso carries C3 then 3C, tx_underrun never set.
REQ-036 Mode 1, no tx_valid given -> tx_underrun pulses once in LOAD, miso all 0, rx byte still captured correctly.
REQ-037 cs deasserted after 5 bits -> state=IDLE, count=0, no rx_valid, rx_data unchanged, holding register retained; the next frame completes normally.
REQ-038 reset pulsed low mid-byte in mode 2 -> all outputs at their REQ-030 values immediately; a following full frame 8'hFF is received as 8'hFF.
